risc_mem_stage: RTL
===================

# risc_mem_stage

Memory-access stage of the pipelined RISC CPU, directly upstream of the writeback stage. It accepts one instruction per cycle from execute and performs the data-memory load or store through a req/ack handshake. It stalls execute while memory is busy and registers the EX/WB pipeline fields that writeback consumes as WB_RW, WB_DA, WB_MD, WB_F, WB_Data_Mem_Data_Out and WB_N_XOR_V.

## Interface
- ACK_TIMEOUT, 15: maximum number of cycles to wait for dmem_ack before aborting (range 1..255).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- EX_Valid  in  1  execute presents an instruction this cycle.
- EX_RW  in  1  register-write enable of the instruction.
- EX_DA  in  5  destination register address.
- EX_MD  in  2  writeback mux select: 0 = F, 1 = memory data, 2 = N^V, 3 = hold.
- EX_MW  in  1  memory-write (store) flag.
- EX_F  in  32  ALU result; also used as the memory address.
- EX_Bus_B  in  32  store data.
- EX_N_XOR_V  in  1  N xor V flag.
- MEM_Stall  out  1  execute must hold its outputs.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  memory address.
- dmem_wdata  out  32  memory write data.
- dmem_rdata  in  32  memory read data, valid while dmem_ack = 1.
- dmem_ack  in  1  memory completion, 1 cycle.
- WB_RW, WB_DA[5], WB_MD[2], WB_F[32], WB_Data_Mem_Data_Out[32], WB_N_XOR_V  out  registered EX/WB fields.
- mem_err  out  1  sticky flag for a timeout abort.

## Operation
- Memory operation: is_mem = EX_MW | (EX_MD == 1).
- FSM states:
  - IDLE → WAIT when EX_Valid & is_mem.
  - WAIT → IDLE when dmem_ack, or when the timeout count reaches ACK_TIMEOUT.
- MEM_Stall = (state == WAIT), decoded from the state register. It is never combinational from the EX_* inputs.
- IDLE, EX_Valid & !is_mem:
  - WB_* load the EX_* fields at the clock edge.
  - WB_Data_Mem_Data_Out holds its value.
- IDLE, EX_Valid & is_mem:
  - The operation is captured into internal registers (RW, DA, MD, F, N_XOR_V, MW, Bus_B).
  - At the same edge, dmem_req is registered to 1, with dmem_we = EX_MW, dmem_addr = EX_F, dmem_wdata = EX_Bus_B.
  - WB_* take a bubble: WB_RW = 0, WB_MD = 0, all other WB fields unchanged.
- IDLE, !EX_Valid: WB_* take a bubble.
- WAIT:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable until ack.
  - WB_* hold the bubble.
  - A 8-bit counter increments each cycle without ack.
- WAIT with dmem_ack:
  - At the next edge, WB_* are loaded from the captured operation.
  - For a load, WB_Data_Mem_Data_Out takes dmem_rdata.
  - dmem_req drops to 0, the counter clears, state → IDLE.
- WAIT with timeout and no ack:
  - At the next edge, mem_err is set to 1 (it clears only on reset).
  - dmem_req drops to 0.
  - WB_* are loaded with the captured fields, but with WB_RW = 0 and WB_Data_Mem_Data_Out = 0.
  - State → IDLE.
- Ack and timeout in the same cycle: ack wins and mem_err is not set.
- dmem_ack while in IDLE is ignored.

## Timing
- Reset (asynchronous, active-low):
  - State → IDLE, counter = 0, mem_err = 0.
  - dmem_req/we/addr/wdata = 0, every WB_* output = 0, MEM_Stall = 0.
  - Reset asserted during WAIT abandons the request immediately.
- Non-memory instruction: WB_* are valid 1 cycle after the acceptance edge.
- Memory operation, acceptance at edge E0:
  - dmem_req is high from E0.
  - The earliest ack is in the cycle after E0.
  - WB_* become valid at the edge following ack, so minimum latency is 2 cycles.
- During WAIT, execute holds its instruction; it is accepted in the first IDLE cycle after WAIT ends.
- Back-to-back memory operations: the second request issues 1 cycle after the first completes, so dmem_req has at least 1 low cycle between them.
- Throughput: 1 instruction/cycle for non-memory traffic.

## Structure
- Shared package risc_pkg holds:
  - MD encodings (MD_F = 0, MD_MEM = 1, MD_NV = 2, MD_HOLD = 3).
  - The mem-stage state enum (IDLE, WAIT).
  - Widths: DATA_W = 32, REG_ADDR_W = 5.
- No sub-module; the timeout counter stays inline.
- Top-level pairing: risc_mem_stage feeds HW5_RISC_WB port-for-port on the WB_* signals.

## Test plan
- ALU op (EX_Valid = 1, RW = 1, DA = 5, MD = 0, F = 0x1234) → next cycle WB_RW = 1, WB_DA = 5, WB_F = 0x1234; MEM_Stall stays 0.
- Load (MD = 1, F = 0x40), memory acks 2 cycles after req with rdata 0xCAFEF00D:
  - dmem_req high for 3 cycles, addr = 0x40, we = 0.
  - Bubble on WB until the edge after ack, then WB_Data_Mem_Data_Out = 0xCAFEF00D, WB_MD = 1.
- Store (MW = 1, F = 0x80, Bus_B = 0xA5A5A5A5), ack same cycle → we = 1, wdata = 0xA5A5A5A5, MEM_Stall high exactly 1 cycle, WB_RW mirrors EX_RW.
- No ack, ACK_TIMEOUT = 4 → mem_err rises after 4 WAIT cycles, dmem_req = 0, WB_RW = 0; mem_err persists over later ops.
- Ack and timeout coincident → data delivered, mem_err = 0.
- Reset pulsed low mid-WAIT → dmem_req, MEM_Stall and all WB_* = 0 immediately; after release, state is IDLE and the next ALU op completes in 1 cycle.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared types and widths for the RISC pipeline.
// Mem-stage state, writeback mux encodings, captured op bundle.
package risc_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MD_F    = 2'd0,
    MD_MEM  = 2'd1,
    MD_NV   = 2'd2,
    MD_HOLD = 2'd3
  } md_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                  rw;
    logic [REG_ADDR_W-1:0] da;
    logic [1:0]            md;
    logic [DATA_W-1:0]     f;
    logic                  nv;
    logic                  mw;
    logic [DATA_W-1:0]     bus_b;
  } mem_op_t;

endpackage

// File: rtl/risc_mem_stage.sv
// Memory-access stage: data-memory req/ack handshake,
// execute stall, and the EX/WB pipeline register.
module risc_mem_stage
  import risc_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EX_Valid,
  input  logic                  EX_RW,
  input  logic [REG_ADDR_W-1:0] EX_DA,
  input  logic [1:0]            EX_MD,
  input  logic                  EX_MW,
  input  logic [DATA_W-1:0]     EX_F,
  input  logic [DATA_W-1:0]     EX_Bus_B,
  input  logic                  EX_N_XOR_V,
  output logic                  MEM_Stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  WB_RW,
  output logic [REG_ADDR_W-1:0] WB_DA,
  output logic [1:0]            WB_MD,
  output logic [DATA_W-1:0]     WB_F,
  output logic [DATA_W-1:0]     WB_Data_Mem_Data_Out,
  output logic                  WB_N_XOR_V,
  output logic                  mem_err
);

  mem_state_e state, state_nx;
  mem_op_t    op;
  logic [7:0] cnt;
  logic       is_mem, ex_alu, accept_mem;
  logic       timeout, done_ack, done_to;

  assign is_mem     = EX_MW | (EX_MD == MD_MEM);
  assign ex_alu     = (state == IDLE) & EX_Valid & ~is_mem;
  assign accept_mem = (state == IDLE) & EX_Valid & is_mem;
  // Fires in the ACK_TIMEOUT-th waiting cycle.
  assign timeout    = (cnt == 8'(ACK_TIMEOUT - 1));
  assign done_ack   = (state == WAIT) & dmem_ack;
  assign done_to    = (state == WAIT) & ~dmem_ack & timeout;

  assign MEM_Stall  = (state == WAIT);
  assign dmem_we    = op.mw;
  assign dmem_addr  = op.f;
  assign dmem_wdata = op.bus_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (EX_Valid & is_mem) state_nx = WAIT;
      WAIT:    if (dmem_ack | timeout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op                   <= '0;
      cnt                  <= '0;
      dmem_req             <= 1'b0;
      mem_err              <= 1'b0;
      WB_RW                <= 1'b0;
      WB_DA                <= '0;
      WB_MD                <= MD_F;
      WB_F                 <= '0;
      WB_Data_Mem_Data_Out <= '0;
      WB_N_XOR_V           <= 1'b0;
    end else begin
      if (state == WAIT && !dmem_ack && !timeout)
        cnt <= cnt + 8'd1;
      else
        cnt <= 8'd0;

      if (accept_mem) begin
        op       <= '{EX_RW, EX_DA, EX_MD, EX_F,
                      EX_N_XOR_V, EX_MW, EX_Bus_B};
        dmem_req <= 1'b1;
      end else if (done_ack | done_to) begin
        dmem_req <= 1'b0;
      end

      if (done_to) mem_err <= 1'b1;

      unique case (1'b1)
        ex_alu: begin
          WB_RW      <= EX_RW;
          WB_DA      <= EX_DA;
          WB_MD      <= EX_MD;
          WB_F       <= EX_F;
          WB_N_XOR_V <= EX_N_XOR_V;
        end
        done_ack: begin
          WB_RW      <= op.rw;
          WB_DA      <= op.da;
          WB_MD      <= op.md;
          WB_F       <= op.f;
          WB_N_XOR_V <= op.nv;
          if (!op.mw) WB_Data_Mem_Data_Out <= dmem_rdata;
        end
        done_to: begin
          WB_RW                <= 1'b0;
          WB_DA                <= op.da;
          WB_MD                <= op.md;
          WB_F                 <= op.f;
          WB_N_XOR_V           <= op.nv;
          WB_Data_Mem_Data_Out <= '0;
        end
        default: begin
          WB_RW <= 1'b0;
          WB_MD <= MD_F;
        end
      endcase
    end
  end

endmodule
